instr_fetch_unit: RTL and testbench

Instruction fetch front end of the 6502 core, sitting directly upstream of the decode stage. Reads opcode and operand bytes over the shared CPU bus whenever the execute stage is not using it and buffers them in a small prefetch queue. Assembles each complete 1–3 byte instruction, together with its opcode address, into one valid/ready transfer to decode. Accepts branch and jump redirects from execute and flushes all speculative state on them.

---
 rtl/cpu6502_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/fetch_byte_queue.sv | 33 +++
 rtl/instr_fetch_unit.sv | 81 ++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared types, constants and opcode length decode for the 6502 fetch front end
package cpu6502_pkg;
    localparam int ADDR_W = 16;
    localparam int QDEPTH_DEFAULT = 4;
    typedef enum logic [1:0] {S_OPCODE, S_OP1, S_OP2, S_PRESENT} fetch_state_e;
    function automatic logic [1:0] ins_len_of(input logic [7:0] op);
        logic [3:0] lo;
        lo = op[3:0];
        if (op == 8'h00 || op == 8'h40 || op == 8'h60 || lo == 4'h8 || lo == 4'hA) return 2'd1;
        if (op == 8'h20 || lo >= 4'hC || ((lo == 4'h9 || lo == 4'hB) && op[4])) return 2'd3;
        return 2'd2;
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: CPU bus, redirect and decode handshake signals of the fetch unit
interface instr_fetch_unit_if;
    import cpu6502_pkg::*;
    logic [ADDR_W-1:0] bus_addr;
    logic bus_rd_req;
    logic bus_grant;
    logic [7:0] bus_rdata;
    logic redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic ins_valid;
    logic ins_ready;
    logic [ADDR_W-1:0] ins_pc;
    logic [7:0] ins_opcode;
    logic [7:0] ins_op1;
    logic [7:0] ins_op2;
    logic [1:0] ins_len;
    modport master (
        output bus_addr, bus_rd_req, ins_valid, ins_pc, ins_opcode, ins_op1, ins_op2, ins_len,
        input bus_grant, bus_rdata, redirect, redirect_pc, ins_ready
    );
    modport slave (
        input bus_addr, bus_rd_req, ins_valid, ins_pc, ins_opcode, ins_op1, ins_op2, ins_len,
        output bus_grant, bus_rdata, redirect, redirect_pc, ins_ready
    );
endinterface

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: synchronous byte FIFO with flush and simultaneous push/pop
module fetch_byte_queue #(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    input logic flush,
    input logic push,
    input logic [7:0] din,
    input logic pop,
    output logic [7:0] dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetches bytes over the shared bus and assembles 1-3 byte instructions for decode
module instr_fetch_unit
    import cpu6502_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int QDEPTH = QDEPTH_DEFAULT
) (
    input logic clk,
    input logic rst,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    fetch_state_e state, state_n;
    logic [ADDR_W-1:0] fetch_pc, head_pc, ins_pc;
    logic [7:0] opcode, op1, op2, head;
    logic [1:0] len, head_len;
    logic [CW-1:0] count;
    logic rd_req, push, pop, hs, load_op;
    assign rd_req = !rst && !bus.redirect && count != CW'(QDEPTH);
    assign push = rd_req && bus.bus_grant;
    assign hs = state == S_PRESENT && bus.ins_ready;
    assign pop = !bus.redirect && count != '0 && (state != S_PRESENT || hs);
    assign load_op = state == S_OPCODE || state == S_PRESENT;
    assign head_len = ins_len_of(head);
    fetch_byte_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk(clk),
        .rst(rst),
        .flush(bus.redirect),
        .push(push),
        .din(bus.bus_rdata),
        .pop(pop),
        .dout(head),
        .count(count)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= S_OPCODE;
        else state <= state_n;
    end
    // a handshake with a byte waiting pops the next opcode directly, avoiding a bubble
    always_comb begin
        state_n = state;
        if (bus.redirect) state_n = S_OPCODE;
        else if (pop) state_n = load_op ? (head_len == 2'd1 ? S_PRESENT : S_OP1)
                                        : (state == S_OP1 && len == 2'd3 ? S_OP2 : S_PRESENT);
        else if (hs) state_n = S_OPCODE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head_pc <= RESET_PC;
            ins_pc <= '0;
            opcode <= '0;
            op1 <= '0;
            op2 <= '0;
            len <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            head_pc <= bus.redirect_pc;
        end else begin
            if (push) fetch_pc <= fetch_pc + ADDR_W'(1);
            if (pop) head_pc <= head_pc + ADDR_W'(1);
            if (pop && load_op) begin
                ins_pc <= head_pc;
                opcode <= head;
                op1 <= '0;
                op2 <= '0;
                len <= head_len;
            end
            if (pop && state == S_OP1) op1 <= head;
            if (pop && state == S_OP2) op2 <= head;
        end
    end
    assign bus.bus_addr = fetch_pc;
    assign bus.bus_rd_req = rd_req;
    assign bus.ins_valid = state == S_PRESENT;
    assign bus.ins_pc = ins_pc;
    assign bus.ins_opcode = opcode;
    assign bus.ins_op1 = op1;
    assign bus.ins_op2 = op2;
    assign bus.ins_len = len;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench comparing decode transfers against an instruction-stream model of memory
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic [7:0] mem [65536];
    int n_cmp = 0;
    int n_err = 0;
    int n_hs = 0;
    logic [41:0] exp_q [$];
    instr_fetch_unit_if bi();
    instr_fetch_unit_if bw();
    instr_fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bi));
    instr_fetch_unit #(.RESET_PC(16'hFFFE), .QDEPTH(4)) dut_wrap (.clk(clk), .rst(rst2), .bus(bw));
    always #5 clk = ~clk;
    assign bi.bus_rdata = mem[bi.bus_addr];
    assign bw.bus_rdata = mem[bw.bus_addr];

    function automatic int ref_len(logic [7:0] op);
        int lo;
        lo = int'(op) % 16;
        if (op == 8'h00 || op == 8'h40 || op == 8'h60 || lo == 8 || lo == 10) return 1;
        if (op == 8'h20 || lo >= 12 || ((lo == 9 || lo == 11) && (int'(op) / 16) % 2 == 1)) return 3;
        return 2;
    endfunction

    function automatic void check(string name, logic [47:0] act, logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void expect_from(logic [15:0] start);
        logic [15:0] pc;
        int l;
        pc = start;
        exp_q.delete();
        repeat (256) begin
            l = ref_len(mem[pc]);
            exp_q.push_back({pc, mem[pc], l > 1 ? mem[pc + 16'd1] : 8'h00,
                             l > 2 ? mem[pc + 16'd2] : 8'h00, 2'(l)});
            pc = pc + 16'(l);
        end
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst && bi.ins_valid && bi.ins_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ins_stream: unexpected transfer pc=%h, expected none", bi.ins_pc);
            end else begin
                check("ins_stream", {bi.ins_pc, bi.ins_opcode, bi.ins_op1, bi.ins_op2, bi.ins_len},
                      exp_q.pop_front());
            end
        end
    end

    task automatic wait_valid(string name, int exp_edges);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1 seen = bi.ins_valid;
        end
        check(name, 48'(n), 48'(exp_edges));
    endtask

    task automatic do_redirect(logic [15:0] pc);
        bi.redirect = 1'b1;
        bi.redirect_pc = pc;
        @(posedge clk);
        #1;
        bi.redirect = 1'b0;
        expect_from(pc);
        check("valid_after_redirect", 48'(bi.ins_valid), 48'd0);
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'hA9;
        mem[16'h0001] = 8'h05;
        mem[16'h0002] = 8'h8D;
        mem[16'h0003] = 8'h00;
        mem[16'h0004] = 8'h02;
        mem[16'h0005] = 8'hEA;
        mem[16'h0300] = 8'h20;
        mem[16'h0301] = 8'h34;
        mem[16'h0302] = 8'h12;
        bi.bus_grant = 1'b1;
        bi.ins_ready = 1'b1;
        bi.redirect = 1'b0;
        bi.redirect_pc = 16'h0000;
        bw.bus_grant = 1'b1;
        bw.ins_ready = 1'b1;
        bw.redirect = 1'b0;
        bw.redirect_pc = 16'h0000;
        run(2);
        check("reset_outputs", 48'({bi.ins_valid, bi.ins_pc, bi.ins_opcode, bi.ins_op1, bi.ins_op2, bi.ins_len}), 48'd0);
        check("reset_rd_req", 48'(bi.bus_rd_req), 48'd0);
        check("reset_bus_addr", 48'(bi.bus_addr), 48'h0000);
        check("reset_bus_addr_wrap", 48'(bw.bus_addr), 48'hFFFE);
        rst = 1'b0;
        expect_from(16'h0000);
        wait_valid("latency_2byte", 3);
        run(12);
        do_redirect(16'h0005);
        wait_valid("latency_1byte", 2);
        run(4);
        do_redirect(16'h0002);
        wait_valid("latency_3byte", 4);
        run(6);
        // bus stealing while the first instruction is still assembling
        do_redirect(16'h0000);
        run(2);
        bi.bus_grant = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stall_bus_addr", 48'(bi.bus_addr), 48'h0002);
            @(posedge clk);
            #1;
        end
        bi.bus_grant = 1'b1;
        run(15);
        bi.ins_ready = 1'b0;
        do_redirect(16'h0000);
        run(10);
        @(negedge clk);
        check("bp_rd_req", 48'(bi.bus_rd_req), 48'd0);
        check("bp_valid", 48'(bi.ins_valid), 48'd1);
        check("bp_hold", 48'({bi.ins_pc, bi.ins_opcode}), 48'h0000A9);
        @(posedge clk);
        #1;
        bi.ins_ready = 1'b1;
        run(15);
        do_redirect(16'h0000);
        run(2);
        do_redirect(16'h0300);
        wait_valid("latency_mid_redirect", 4);
        run(10);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = bi.ins_valid;
        end
        check("coincide_seen", 48'(found), 48'd1);
        do_redirect(16'h0300);
        run(12);
        repeat (400) begin
            @(posedge clk);
            #1;
            bi.bus_grant = $urandom_range(0, 9) < 7;
            bi.ins_ready = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 29) == 0) do_redirect(16'($urandom));
        end
        bi.ins_ready = 1'b0;
        rst = 1'b1;
        run(1);
        check("midrst_valid", 48'(bi.ins_valid), 48'd0);
        check("midrst_rd_req", 48'(bi.bus_rd_req), 48'd0);
        check("midrst_bus_addr", 48'(bi.bus_addr), 48'h0000);
        rst = 1'b0;
        expect_from(16'h0000);
        bi.ins_ready = 1'b1;
        bi.bus_grant = 1'b1;
        wait_valid("latency_after_rst", 3);
        run(10);
        rst = 1'b1;
        mem[16'hFFFE] = 8'h4C;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        run(1);
        rst2 = 1'b0;
        run(3);
        check("wrap_fetch_pc", 48'(bw.bus_addr), 48'h0001);
        run(1);
        check("wrap_valid", 48'(bw.ins_valid), 48'd1);
        check("wrap_ins", 48'({bw.ins_pc, bw.ins_opcode, bw.ins_op1, bw.ins_op2, bw.ins_len}),
              48'({16'hFFFE, 8'h4C, 8'h34, 8'h12, 2'd3}));
        check("handshakes_seen", 48'(n_hs >= 50), 48'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
